// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one line-wide memory port between an instruction-side requester (i_*)
//   and a data-side requester (d_*). Each transaction moves one line: a read
//   returns LINE_SIZE bits on the owner's rdata, and a write sends the owner's
//   wdata. When both sides request, a 1-bit last-served flag picks the side
//   that was not served last. A WAIT-state counter aborts a transaction when
//   memory never answers. In that case the sticky err flag is raised and the
//   owner still receives its done pulse, with rdata forced to zero.
//
// Parameters:
//   WORD_SIZE  address width
//   LINE_SIZE  line data width (four words)
//   TIMEOUT    WAIT cycles without m_valid before the transaction is aborted
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   i_req/i_write/i_addr/i_wdata instruction-side request, held until i_done
//   i_rdata/i_done               instruction-side read line and done pulse
//   d_req/d_write/d_addr/d_wdata data-side request, held until d_done
//   d_rdata/d_done               data-side read line and done pulse
//   m_readM/m_writeM             one-cycle memory read/write strobes
//   m_addr/m_wdata               memory address and write line
//   m_rdata/m_valid              memory read line and completion
//   busy                         high whenever the FSM is not IDLE
//   err                          sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic                 i_write,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [LINE_SIZE-1:0] i_wdata,
  output logic [LINE_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [LINE_SIZE-1:0] d_wdata,
  output logic [LINE_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_addr,
  output logic [LINE_SIZE-1:0] m_wdata,
  input  logic [LINE_SIZE-1:0] m_rdata,
  input  logic                 m_valid,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_lastD;   // 1 when the data side was granted last
  logic                  r_ownerD;  // 1 when the data side owns the transaction
  logic [3:0]            r_waitCnt;

  logic                  w_grantD;
  logic                  w_winWrite;
  logic [WORD_SIZE-1:0]  w_winAddr;
  logic [LINE_SIZE-1:0]  w_winWdata;

  // A lone requester always wins. On a tie, the side not served last wins.
  assign w_grantD   = d_req && (!i_req || !r_lastD);
  assign w_winWrite = w_grantD ? d_write : i_write;
  assign w_winAddr  = w_grantD ? d_addr  : i_addr;
  assign w_winWdata = w_grantD ? d_wdata : i_wdata;

  // The strobe, m_addr and m_wdata are loaded at the grant edge. This lets them
  // appear, already registered, during the ISSUE cycle. m_addr/m_wdata then
  // hold the latched request for the rest of the transaction. The strobes and
  // the done pulses default to zero, so each one lasts a single cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_lastD   <= 1'b1;
      r_ownerD  <= 1'b0;
      r_waitCnt <= 4'd0;
      i_rdata   <= '0;
      i_done    <= 1'b0;
      d_rdata   <= '0;
      d_done    <= 1'b0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      m_readM  <= 1'b0;
      m_writeM <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req || d_req) begin
            r_ownerD <= w_grantD;
            r_lastD  <= w_grantD;
            m_readM  <= !w_winWrite;
            m_writeM <= w_winWrite;
            m_addr   <= w_winAddr;
            m_wdata  <= w_winWdata;
            busy     <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_waitCnt <= 4'd0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (m_valid) begin
            if (r_ownerD) begin
              d_rdata <= m_rdata;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_done  <= 1'b1;
            end
            r_state <= RESP;
          end else if (r_waitCnt == 4'(TIMEOUT - 1)) begin
            // Memory never answered: abort, return a zero line, flag the error.
            err <= 1'b1;
            if (r_ownerD) begin
              d_rdata <= '0;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_done  <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        RESP: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. A small memory model answers each
//   strobe four edges later with a line derived from the address. A monitor
//   compares every memory command and every done pulse against scoreboard
//   queues. The bench pushes onto those queues whenever it drives a request.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WS = 16;
  localparam int LS = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0, i_write = 1'b0;
  logic [WS-1:0] i_addr = '0;
  logic [LS-1:0] i_wdata = '0;
  logic [LS-1:0] i_rdata;
  logic          i_done;
  logic          d_req = 1'b0, d_write = 1'b0;
  logic [WS-1:0] d_addr = '0;
  logic [LS-1:0] d_wdata = '0;
  logic [LS-1:0] d_rdata;
  logic          d_done;
  logic          m_readM, m_writeM;
  logic [WS-1:0] m_addr;
  logic [LS-1:0] m_wdata;
  logic [LS-1:0] m_rdata;
  logic          m_valid;
  logic          busy, err;

  mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            write;
    logic [WS-1:0] addr;
    logic [LS-1:0] wdata;
  } cmd_t;

  typedef struct {
    bit            isD;
    logic [LS-1:0] rdata;
    int            latency;
  } resp_t;

  typedef struct {
    bit            isD;
    bit            write;
    logic [WS-1:0] addr;
    logic [LS-1:0] wdata;
  } vec_t;

  cmd_t  cmdQ[$];
  resp_t respQ[$];
  int    strobeLog[$];
  int    tests = 0;
  int    fails = 0;
  int    cycle = 0;
  int    lastStrobeCycle = -100;
  bit    prevStrobe = 1'b0;

  // Memory model state
  int            memCnt = 0;
  bit            memRespond = 1'b1;
  bit            modelValid = 1'b0;
  bit            forceValid = 1'b0;
  logic [WS-1:0] memAddr = '0;

  function automatic logic [LS-1:0] memLine(input logic [WS-1:0] a);
    return {a, 16'hC0DE, ~a, 16'h5A5A};
  endfunction

  assign m_valid = modelValid | forceValid;
  assign m_rdata = modelValid ? memLine(memAddr) : (forceValid ? 64'hDEAD_BEEF_DEAD_BEEF : '0);

  always @(posedge clk) cycle++;

  // The memory answers four edges after the edge that samples the strobe.
  always @(posedge clk) begin
    #1;
    modelValid = 1'b0;
    if (memCnt > 0) begin
      memCnt--;
      if (memCnt == 0 && memRespond) modelValid = 1'b1;
    end
    if ((m_readM || m_writeM) && memCnt == 0) begin
      memCnt  = 4;
      memAddr = m_addr;
    end
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares memory commands and done pulses against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_readM || m_writeM) begin
        strobeLog.push_back(cycle);
        lastStrobeCycle = cycle;
        checkOutput("strobe width", 64'(prevStrobe), 64'd0);
        if (cmdQ.size() == 0) begin
          checkOutput("unexpected strobe", 64'(m_readM | m_writeM), 64'd0);
        end else begin
          cmd_t c;
          c = cmdQ.pop_front();
          checkOutput("strobe kind", {62'd0, m_writeM, m_readM}, {62'd0, c.write, !c.write});
          checkOutput("m_addr", 64'(m_addr), 64'(c.addr));
          if (c.write) checkOutput("m_wdata", m_wdata, c.wdata);
        end
      end
      prevStrobe = m_readM || m_writeM;
      if (i_done || d_done) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected done", {62'd0, d_done, i_done}, 64'd0);
        end else begin
          resp_t r;
          r = respQ.pop_front();
          checkOutput("done side", {62'd0, d_done, i_done}, r.isD ? 64'd2 : 64'd1);
          checkOutput("rdata", r.isD ? d_rdata : i_rdata, r.rdata);
          checkOutput("done latency", 64'(cycle - lastStrobeCycle), 64'(r.latency));
        end
      end
    end
  end

  // Pushes the command and response the DUT is expected to produce.
  task automatic expectTxn(input vec_t v, input int lat, input logic [LS-1:0] rd);
    cmd_t  c;
    resp_t r;
    c.write = v.write; c.addr = v.addr; c.wdata = v.wdata;
    r.isD = v.isD; r.rdata = rd; r.latency = lat;
    cmdQ.push_back(c);
    respQ.push_back(r);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isD) begin
      d_write = v.write; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_write = v.write; i_addr = v.addr; i_wdata = v.wdata; i_req = 1'b1;
    end
  endtask

  // Waits for a done pulse and drops that requester's req within its done cycle.
  task automatic waitDone(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(i_done || d_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(i_done || d_done)) begin
      checkOutput("waitDone timeout", 64'(i_done | d_done), 64'd1);
    end else begin
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input bit isD, input bit wr, input logic [WS-1:0] a, input logic [LS-1:0] wd);
    vec_t v;
    v.isD = isD; v.write = wr; v.addr = a; v.wdata = wd;
    return v;
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t va, vb;
    int   base;
    int   n;

    vecs[0] = mk(1'b0, 1'b0, 16'h0023, 64'h0);
    vecs[1] = mk(1'b1, 1'b1, 16'h0040, 64'h1111_2222_3333_4444);
    vecs[2] = mk(1'b1, 1'b0, 16'hFFFF, 64'h0);
    vecs[3] = mk(1'b0, 1'b1, 16'h1234, 64'hA5A5_0F0F_F0F0_5A5A);
    vecs[4] = mk(1'b0, 1'b0, 16'h0000, 64'h0);
    vecs[5] = mk(1'b1, 1'b0, 16'h8001, 64'h0);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset err", 64'(err), 64'd0);
    checkOutput("reset strobes", {62'd0, m_readM, m_writeM}, 64'd0);
    checkOutput("reset dones", {62'd0, i_done, d_done}, 64'd0);
    checkOutput("reset m_addr", 64'(m_addr), 64'd0);
    checkOutput("reset i_rdata", i_rdata, 64'd0);
    checkOutput("reset d_rdata", d_rdata, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-requester vector table
    foreach (vecs[k]) begin
      expectTxn(vecs[k], 5, memLine(vecs[k].addr));
      applyStimulus(vecs[k]);
      waitDone(40);
    end

    // Tie after reset: I first, then D granted 7 cycles later
    doReset();
    va = mk(1'b0, 1'b0, 16'h0100, 64'h0);
    vb = mk(1'b1, 1'b0, 16'h0200, 64'h0);
    expectTxn(va, 5, memLine(va.addr));
    expectTxn(vb, 5, memLine(vb.addr));
    base = strobeLog.size();
    applyStimulus(va);
    applyStimulus(vb);
    waitDone(40);
    waitDone(40);
    if (strobeLog.size() >= base + 2)
      checkOutput("tie grant spacing", 64'(strobeLog[base+1] - strobeLog[base]), 64'd7);
    else
      checkOutput("tie strobe count", 64'(strobeLog.size() - base), 64'd2);

    // I served alone, then a tie must go to D first
    va = mk(1'b0, 1'b0, 16'h0300, 64'h0);
    expectTxn(va, 5, memLine(va.addr));
    applyStimulus(va);
    waitDone(40);
    va = mk(1'b1, 1'b0, 16'h0400, 64'h0);
    vb = mk(1'b0, 1'b1, 16'h0500, 64'h0123_4567_89AB_CDEF);
    expectTxn(va, 5, memLine(va.addr));
    expectTxn(vb, 5, memLine(vb.addr));
    applyStimulus(va);
    applyStimulus(vb);
    waitDone(40);
    waitDone(40);

    // Timeout: no m_valid, err sets and done pulses with a zero line
    memRespond = 1'b0;
    va = mk(1'b0, 1'b0, 16'h0600, 64'h0);
    expectTxn(va, 16, 64'd0);
    applyStimulus(va);
    waitDone(40);
    checkOutput("err after timeout", 64'(err), 64'd1);
    repeat (4) @(negedge clk);
    memRespond = 1'b1;
    va = mk(1'b1, 1'b0, 16'h0610, 64'h0);
    expectTxn(va, 5, memLine(va.addr));
    applyStimulus(va);
    waitDone(40);
    @(negedge clk);
    checkOutput("err sticky", 64'(err), 64'd1);
    doReset();
    @(negedge clk);
    checkOutput("err cleared by reset", 64'(err), 64'd0);

    // Reset during WAIT: transaction dropped, no done, stray m_valid ignored
    va = mk(1'b0, 1'b0, 16'h0700, 64'h0);
    begin
      cmd_t c;
      c.write = 1'b0; c.addr = va.addr; c.wdata = '0;
      cmdQ.push_back(c);
    end
    applyStimulus(va);
    n = 0;
    @(negedge clk);
    while (!m_readM && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset-in-wait strobe seen", 64'(m_readM), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("busy after mid reset", 64'(busy), 64'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("idle after mid reset", {61'd0, busy, i_done, d_done}, 64'd0);
    end

    // Spurious m_valid in IDLE
    forceValid = 1'b1;
    @(negedge clk);
    forceValid = 1'b0;
    @(negedge clk);
    checkOutput("spurious valid state", {60'd0, busy, i_done, d_done, m_readM}, 64'd0);
    checkOutput("spurious valid i_rdata", i_rdata, 64'd0);

    repeat (3) @(negedge clk);
    checkOutput("cmd queue drained", 64'(cmdQ.size()), 64'd0);
    checkOutput("resp queue drained", 64'(respQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
